uart_rx_fifo: RTL and testbench

- Receive half of the host serial link. It deserialises 8-bit UART frames from the rx pin, checks parity and stop bits, and buffers the bytes in a show-ahead FIFO.
- It sits directly upstream of the host communication interface. That interface pops bytes with rd_en/rx_data/rx_empty and latches parity_err into its error code.

---
 rtl/uart_rx_fifo.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling, parity/stop checking and a show-ahead byte FIFO.
// Bytes with bad parity are kept and flagged; bytes with a bad stop bit are dropped.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line idle, waiting for synced rx to go low
// S_START  | counting to mid start bit, re-checking for a glitch
// S_DATA   | sampling DATA_BITS data bits, LSB first
// S_PARITY | sampling the parity bit (skipped when PARITY_MODE = 0)
// S_STOP   | sampling the stop bit, then push or flag a framing error
module uart_rx_fifo #(
  parameter int SYS_CLK_FREQ   = 100000000,
  parameter int BAUD_RATE      = 38400,
  parameter int DATA_BITS      = 8,
  parameter int PARITY_MODE    = 1,
  parameter int FIFO_ADDR_BITS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] rx_data,
  output logic       rx_empty,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow
);

  localparam int DIV_RAW = SYS_CLK_FREQ / (BAUD_RATE * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEPTH   = 1 << FIFO_ADDR_BITS;
  localparam int PW      = FIFO_ADDR_BITS + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic             rx_meta;
  logic             rx_sync;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  state_t           state;
  logic [3:0]       s_cnt;
  logic [3:0]       n_cnt;
  logic [7:0]       data_sr;
  logic             par_bad;
  logic             push;
  logic [7:0]       mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             pop;
  logic             wr;

  // Synchroniser resets to the idle line level so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  assign tick = (div_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= DIV_W'(DIV - 1);
    end else begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

  // The push is decoded from the stop-sample cycle itself so the byte lands one cycle later.
  assign push = tick && (state == S_STOP) && (s_cnt == 4'd15) && rx_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      s_cnt      <= '0;
      n_cnt      <= '0;
      data_sr    <= '0;
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (tick) begin
        case (state)
          S_IDLE: begin
            if (!rx_sync) begin
              s_cnt <= '0;
              state <= S_START;
            end
          end
          S_START: begin
            if (s_cnt == 4'd7) begin
              if (rx_sync) begin
                state <= S_IDLE;
              end else begin
                s_cnt   <= '0;
                n_cnt   <= '0;
                data_sr <= '0;
                par_bad <= 1'b0;
                state   <= S_DATA;
              end
            end else begin
              s_cnt <= s_cnt + 4'd1;
            end
          end
          S_DATA: begin
            s_cnt <= s_cnt + 4'd1;
            if (s_cnt == 4'd15) begin
              data_sr[n_cnt[2:0]] <= rx_sync;
              n_cnt <= n_cnt + 4'd1;
              if (n_cnt == 4'(DATA_BITS - 1)) begin
                state <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
              end
            end
          end
          S_PARITY: begin
            s_cnt <= s_cnt + 4'd1;
            if (s_cnt == 4'd15) begin
              // data_sr is zero padded, so its reduction xor covers only the data bits
              if (PARITY_MODE == 2) begin
                par_bad <= (^data_sr) ^ rx_sync;
              end else begin
                par_bad <= ~((^data_sr) ^ rx_sync);
              end
              state <= S_STOP;
            end
          end
          S_STOP: begin
            s_cnt <= s_cnt + 4'd1;
            if (s_cnt == 4'd15) begin
              if (rx_sync) begin
                parity_err <= par_bad;
              end else begin
                frame_err <= 1'b1;
              end
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FIFO_ADDR_BITS] != rd_ptr[FIFO_ADDR_BITS]) &&
                 (wr_ptr[FIFO_ADDR_BITS-1:0] == rd_ptr[FIFO_ADDR_BITS-1:0]);
  assign pop   = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign wr    = push && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && full && !pop;
      if (wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr[FIFO_ADDR_BITS-1:0]] <= data_sr;
    end
  end

  assign rx_empty = empty;
  assign rx_data  = empty ? 8'h00 : mem[rd_ptr[FIFO_ADDR_BITS-1:0]];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed and random frames checked cycle by cycle against a queue model.
module tb_uart_rx_fifo;

  localparam int SYS       = 1600;
  localparam int BAUD      = 100;
  localparam int DB        = 8;
  localparam int FA        = 3;
  localparam int DEPTH     = 1 << FA;
  localparam int FRAME_CYC = 16 * (DB + 3);
  // line low after drive edge 0: 2 sync flops, IDLE->START, 8 ticks to mid start, then 16 per bit
  localparam int STOP_EDGE = 11 + 16 * (DB + 2);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;
  logic       rx_e = 1'b1;
  logic       rd_en_e = 1'b0;
  logic [7:0] rx_data_e;
  logic       rx_empty_e;
  logic       parity_err_e;
  logic       frame_err_e;
  logic       overflow_e;

  always #5 clk = ~clk;

  uart_rx_fifo #(.SYS_CLK_FREQ(SYS), .BAUD_RATE(BAUD), .DATA_BITS(DB),
                 .PARITY_MODE(1), .FIFO_ADDR_BITS(FA)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en), .rx_data(rx_data),
    .rx_empty(rx_empty), .parity_err(parity_err), .frame_err(frame_err),
    .overflow(overflow));

  uart_rx_fifo #(.SYS_CLK_FREQ(SYS), .BAUD_RATE(BAUD), .DATA_BITS(DB),
                 .PARITY_MODE(2), .FIFO_ADDR_BITS(FA)) dut_even (
    .clk(clk), .rst(rst), .rx(rx_e), .rd_en(rd_en_e), .rx_data(rx_data_e),
    .rx_empty(rx_empty_e), .parity_err(parity_err_e), .frame_err(frame_err_e),
    .overflow(overflow_e));

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] q[$];
  bit         exp_par = 0;
  bit         exp_frm = 0;
  bit         exp_ovf = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, check outputs, then advance the model across the next edge.
  task automatic step(input logic rx_v, input logic rd_v, input bit ev,
                      input logic [7:0] b, input bit pbad, input bit sok);
    bit pop;
    @(posedge clk);
    #1;
    rx    = rx_v;
    rd_en = rd_v;
    @(negedge clk);
    chk("rx_empty", rx_empty, q.size() == 0);
    if (q.size() > 0) chk("rx_data", rx_data, q[0]);
    chk("parity_err", parity_err, exp_par);
    chk("frame_err", frame_err, exp_frm);
    chk("overflow", overflow, exp_ovf);
    exp_par = 0;
    exp_frm = 0;
    exp_ovf = 0;
    pop = rd_v && (q.size() > 0);
    if (ev) begin
      if (sok) begin
        exp_par = pbad;
        if (q.size() == DEPTH && !pop) begin
          exp_ovf = 1;
        end else begin
          if (pop) begin
            void'(q.pop_front());
            pop = 0;
          end
          q.push_back(b);
        end
      end else begin
        exp_frm = 1;
      end
    end
    if (pop) void'(q.pop_front());
  endtask

  task automatic idle(input int n, input int rd_pct);
    for (int i = 0; i < n; i++) step(1'b1, $urandom_range(0, 99) < rd_pct, 0, 8'h00, 0, 1);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit pflip, input bit sbad,
                            input int rd_pct, input bit rd_at_push, input int cut);
    logic [10:0] bits;
    logic        rdv;
    bits = {~sbad, (~^b) ^ pflip, b, 1'b0};
    for (int c = 0; c < FRAME_CYC; c++) begin
      if (cut > 0 && c >= cut) break;
      rdv = ($urandom_range(0, 99) < rd_pct) || (rd_at_push && (c + 1 == STOP_EDGE));
      step(bits[c / 16], rdv, (c + 1 == STOP_EDGE) && (cut == 0), b, pflip, !sbad);
    end
    if (sbad) idle(24, 0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    rx    = 1'b1;
    rd_en = 1'b0;
    q.delete();
    exp_par = 0;
    exp_frm = 0;
    exp_ovf = 0;
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 8'h00, 0, 1);
    chk("rst_rx_data", rx_data, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic send_even(input logic [7:0] b, input logic pbit, output int np, output int nf);
    logic [10:0] bits;
    bits = {1'b1, pbit, b, 1'b0};
    np = 0;
    nf = 0;
    for (int c = 0; c < FRAME_CYC + 12; c++) begin
      @(posedge clk);
      #1;
      if (c < FRAME_CYC) rx_e = bits[c / 16];
      else rx_e = 1'b1;
      @(negedge clk);
      np += int'(parity_err_e);
      nf += int'(frame_err_e);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, n_chk %0d", n_chk);
    $fatal(1);
  end

  initial begin
    int np;
    int nf;
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_empty", rx_empty, 1);
    chk("reset_data", rx_data, 8'h00);
    chk("reset_pulses", {parity_err, frame_err, overflow}, 3'b000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(40, 0);

    // good byte, then single pop
    send_frame(8'hA5, 0, 0, 0, 0, 0);
    idle(3, 0);
    step(1'b1, 1'b1, 0, 8'h00, 0, 1);
    idle(2, 0);

    // parity error byte is kept; framing error byte is not
    send_frame(8'h01, 1, 0, 0, 0, 0);
    send_frame(8'h03, 0, 1, 0, 0, 0);
    idle(4, 100);

    // overflow, drain, and wrap
    for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i), 0, 0, 0, 0, 0);
    idle(12, 100);
    for (int i = 0; i < 5; i++) send_frame(8'h20 + 8'(i), 0, 0, 0, 0, 0);
    idle(8, 100);

    // glitch, then reset mid-frame
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 8'h00, 0, 1);
    idle(40, 0);
    send_frame(8'h5A, 0, 0, 0, 0, 80);
    do_reset(3);
    idle(20, 0);
    send_frame(8'h3C, 0, 0, 0, 0, 0);
    idle(4, 100);

    // push into a full FIFO with a simultaneous pop
    for (int i = 0; i < DEPTH; i++) send_frame(8'h60 + 8'(i), 0, 0, 0, 0, 0);
    send_frame(8'h77, 0, 0, 0, 1, 0);
    idle(12, 100);

    // even parity instance
    send_even(8'hA5, 1'b0, np, nf);
    chk("even_good_par", np, 0);
    chk("even_good_frm", nf, 0);
    chk("even_empty", rx_empty_e, 0);
    chk("even_data", rx_data_e, 8'hA5);
    @(posedge clk);
    #1;
    rd_en_e = 1'b1;
    @(posedge clk);
    #1;
    rd_en_e = 1'b0;
    @(negedge clk);
    chk("even_popped", rx_empty_e, 1);
    send_even(8'hA5, 1'b1, np, nf);
    chk("even_bad_par", np, 1);
    chk("even_bad_data", rx_data_e, 8'hA5);

    // random traffic
    for (int i = 0; i < 30; i++) begin
      send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 2), $urandom_range(0, 5) == 0, 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 30), $urandom_range(0, 30));
    end
    idle(12, 100);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
